// File: rtl/uart_rx_os.sv
// UART receiver: oversampled bit timing with 2-of-3 majority per bit, optional parity,
// 1 or 2 stop bits, break detection and a one-entry valid/ready holding register.
module uart_rx_os #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic [2:0]           dbg_state
);
  // Handshake: a word transfers on the rising edge where rx_valid && rx_ready; from the
  // edge rx_valid rises until that transfer, rx_data and both flags do not change.
  localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0]  T_S0      = OS_W'(M - 1);
  localparam logic [OS_W-1:0]  T_S1      = OS_W'(M);
  localparam logic [OS_W-1:0]  T_DEC     = OS_W'(M + 1);
  localparam logic [OS_W-1:0]  T_END     = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
    S_PARITY = 3'd3, S_STOP = 3'd4, S_BREAK = 3'd5
  } state_t;

  state_t               r_state, w_next;
  logic                 r_sync1, r_sync2;
  logic [DIV_W-1:0]     r_div;
  logic [OS_W-1:0]      r_tick_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s0, r_s1, r_par_bit, r_perr, r_ferr, r_stop1;
  logic                 w_rx, w_tick, w_decide, w_bit_end, w_maj, w_start;
  logic                 w_stop1, w_done, w_break, w_good, w_load, w_drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx      = r_sync2;
  assign w_tick    = (r_div == DIV_LAST);
  assign w_decide  = w_tick && (r_tick_cnt == T_DEC);
  assign w_bit_end = w_tick && (r_tick_cnt == T_END);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_start   = (r_state == S_IDLE) && !w_rx;
  assign dbg_state = r_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_rx) w_next = S_START;
      S_START:  if (w_decide && w_maj) w_next = S_IDLE;
                else if (w_bit_end) w_next = S_DATA;
      S_DATA:   if (w_bit_end && (r_bit_cnt == DATA_LAST))
                  w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_next = S_STOP;
      S_STOP:   if (w_done) w_next = w_break ? S_BREAK : S_IDLE;
      S_BREAK:  if (w_rx) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Frame completes on the last stop bit's decision tick, not at the end of that bit.
  always_comb begin
    w_stop1 = (STOP_BITS == 1) ? w_maj : r_stop1;
    w_done  = (r_state == S_STOP) && w_decide && (r_bit_cnt == STOP_LAST);
    w_break = w_done && (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && !w_stop1;
    w_good  = w_done && !w_break;
    w_load  = w_good && (!rx_valid || rx_ready);
    w_drop  = w_good && rx_valid && !rx_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div      <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop1    <= 1'b1;
    end else if (w_start) begin
      r_div      <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_par_bit  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop1    <= 1'b1;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_tick_cnt <= (r_tick_cnt == T_END) ? '0 : r_tick_cnt + 1'b1;
      if (w_tick && (r_tick_cnt == T_S0)) r_s0 <= w_rx;
      if (w_tick && (r_tick_cnt == T_S1)) r_s1 <= w_rx;
      if (w_decide) begin
        case (r_state)
          S_DATA:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          S_PARITY: begin
            r_par_bit <= w_maj;
            r_perr    <= ^r_shift ^ w_maj ^ (PARITY == 2);
          end
          S_STOP: begin
            if (!w_maj) r_ferr <= 1'b1;
            if (r_bit_cnt == 4'd0) r_stop1 <= w_maj;
          end
          default: ;
        endcase
      end
      if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP)))
        r_bit_cnt <= ((r_state == S_DATA) && (r_bit_cnt == DATA_LAST)) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
      break_det     <= 1'b0;
    end else begin
      overrun   <= w_drop;
      break_det <= w_done && w_break;
      if (w_load) begin
        rx_data       <= r_shift;
        rx_parity_err <= r_perr;
        rx_frame_err  <= r_ferr | !w_maj;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance (a) and an 8E2 instance (b) driven by bit-accurate
// line waveforms, checked against a frame-level model and a holding-register queue.
module tb_uart_rx_os;
  localparam int CF  = 1536000;
  localparam int BR  = 9600;
  localparam int OS  = 16;
  localparam int BIT = 160;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_a, rdy_a, rx_b, rdy_b;
  logic [7:0] data_a, data_b;
  logic       pe_a, fe_a, v_a, ovr_a, brk_a;
  logic       pe_b, fe_b, v_b, ovr_b, brk_b;
  logic [2:0] st_a, st_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];
  int vcyc[2], acc_cnt[2], ovr_cnt[2], brk_cnt[2], exp_ovr[2], exp_brk[2];
  int rise_cyc[2], start_cyc[2];
  logic prev_v[2];
  logic [9:0] last_w[2];

  uart_rx_os #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .OVERSAMPLE(OS)) u_a (
    .clock(clock), .reset_n(reset_n), .rx(rx_a), .rx_data(data_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_valid(v_a), .rx_ready(rdy_a),
    .overrun(ovr_a), .break_det(brk_a), .dbg_state(st_a));

  uart_rx_os #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1),
               .STOP_BITS(2), .OVERSAMPLE(OS)) u_b (
    .clock(clock), .reset_n(reset_n), .rx(rx_b), .rx_data(data_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_valid(v_b), .rx_ready(rdy_b),
    .overrun(ovr_b), .break_det(brk_b), .dbg_state(st_b));

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail_none(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got word %0h, required no word", name, act);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  // ---------------- model ----------------
  // {break, frame_err, parity_err, data}; instance 1 uses even parity and two stop bits
  function automatic logic [10:0] model(input int id, input logic [7:0] d, input logic p,
                                        input logic s1, input logic s2);
    logic perr, ferr, brk;
    perr = (id == 1) ? (^d ^ p) : 1'b0;
    ferr = !s1 || ((id == 1) && !s2);
    brk  = (d == 8'h00) && ((id == 0) || !p) && !s1;
    return {brk, ferr, perr, d};
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic logic [9:0] qfront(input int id);
    return (id == 0) ? exp_q_a[0] : exp_q_b[0];
  endfunction

  function automatic void qpop(input int id);
    if (id == 0) void'(exp_q_a.pop_front());
    else         void'(exp_q_b.pop_front());
  endfunction

  function automatic void qpush(input int id, input logic [9:0] w);
    if (id == 0) exp_q_a.push_back(w);
    else         exp_q_b.push_back(w);
  endfunction

  function automatic logic rdy_of(input int id);
    return (id == 0) ? rdy_a : rdy_b;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic observe(input int id, input logic v, input logic rdy, input logic [9:0] w,
                         input logic ovr, input logic brk);
    if (v) begin
      vcyc[id]++;
      if (!prev_v[id]) rise_cyc[id] = cyc;
      if (qsize(id) == 0) fail_none($sformatf("word%0d_unexpected", id), w);
      else begin
        check($sformatf("word%0d", id), w, qfront(id));
        if (rdy) begin
          qpop(id);
          last_w[id] = w;
          acc_cnt[id]++;
        end
      end
    end
    if (ovr) ovr_cnt[id]++;
    if (brk) brk_cnt[id]++;
    prev_v[id] = v;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      observe(0, v_a, rdy_a, {fe_a, pe_a, data_a}, ovr_a, brk_a);
      observe(1, v_b, rdy_b, {fe_b, pe_b, data_b}, ovr_b, brk_b);
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_rx(input int id, input logic val);
    if (id == 0) rx_a = val;
    else         rx_b = val;
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input int spike, input bit use_model);
    logic line [0:12];
    logic [10:0] m;
    int n;
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i+1] = d[i];
    n = 9;
    if (id == 1) begin line[n] = p; n++; end
    line[n] = s1; n++;
    if (id == 1) begin line[n] = s2; n++; end
    if (use_model) begin
      m = model(id, d, p, s1, s2);
      if (m[10]) exp_brk[id]++;
      else if ((qsize(id) != 0) && !rdy_of(id)) exp_ovr[id]++;
      else qpush(id, m[9:0]);
    end
    start_cyc[id] = cyc;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < BIT; k++) begin
        drive_rx(id, ((i == spike) && (k >= 75) && (k < 85)) ? !line[i] : line[i]);
        @(posedge clock);
        #1;
      end
    end
    drive_rx(id, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int id, v0;
  logic [7:0] d;
  logic p, s1, s2;

  initial begin
    for (int i = 0; i < 2; i++) begin
      vcyc[i] = 0; acc_cnt[i] = 0; ovr_cnt[i] = 0; brk_cnt[i] = 0;
      exp_ovr[i] = 0; exp_brk[i] = 0; rise_cyc[i] = 0; start_cyc[i] = 0;
      prev_v[i] = 1'b0; last_w[i] = '0;
    end
    reset_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    idle(5);
    check("rst_data_a", data_a, 0);
    check("rst_valid_a", v_a, 0);
    check("rst_perr_a", pe_a, 0);
    check("rst_ferr_a", fe_a, 0);
    check("rst_ovr_a", ovr_a, 0);
    check("rst_brk_a", brk_a, 0);
    check("rst_state_a", st_a, 0);
    check("rst_data_b", data_b, 0);
    check("rst_valid_b", v_b, 0);
    reset_n = 1'b1;
    idle(20);

    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1, 1);
    idle(100);
    check("a5_word", last_w[0], 10'h0A5);
    check("a5_valid_cycles", vcyc[0], 1);
    check_range("a5_latency", rise_cyc[0] - start_cyc[0], 1535, 1550);

    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1, 0);
      begin
        idle(700);
        reset_n = 1'b0;
      end
    join
    idle(200);
    check("midrst_state", st_a, 0);
    check("midrst_valid", v_a, 0);
    reset_n = 1'b1;
    idle(20);
    check("midrst_no_word", vcyc[0], 1);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 1);
    idle(100);
    check("5a_word", last_w[0], 10'h05A);

    rx_a = 1'b0;
    idle(40);
    rx_a = 1'b1;
    idle(200);
    check("glitch_state", st_a, 0);
    check("glitch_no_word", vcyc[0], 2);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, 4, 1);
    idle(100);
    check("spike_word", last_w[0], 10'h081);

    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, -1, 1);
    idle(200);
    check("stop0_word", last_w[0], 10'h255);

    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, -1, 1);
    idle(200);
    check("par_bad_word", last_w[1], 10'h13C);
    send_frame(1, 8'h3C, 1'b0, 1'b1, 1'b1, -1, 1);
    idle(200);
    check("par_ok_word", last_w[1], 10'h03C);
    send_frame(1, 8'h55, 1'b0, 1'b1, 1'b0, -1, 1);
    idle(200);
    check("stop2_word", last_w[1], 10'h255);

    rdy_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, -1, 1);
    idle(200);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, 1);
    idle(200);
    check("ovr_pulses", ovr_cnt[0], 1);
    check("ovr_hold_valid", v_a, 1);
    check("ovr_hold_data", data_a, 8'h11);
    rdy_a = 1'b1;
    idle(3);
    check("ovr_drain_valid", v_a, 0);
    check("ovr_drain_word", last_w[0], 10'h011);

    v0 = vcyc[0];
    rx_a = 1'b0;
    exp_brk[0]++;
    idle(3200);
    rx_a = 1'b1;
    idle(200);
    check("brk_pulses", brk_cnt[0], 1);
    check("brk_no_word", vcyc[0] - v0, 0);
    check("brk_state", st_a, 0);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1, -1, 1);
    idle(100);
    check("post_brk_word", last_w[0], 10'h07E);

    for (int f = 0; f < 16; f++) begin
      id = $urandom_range(0, 1);
      d  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      p  = ^d ^ ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      if (id == 0) rdy_a = ($urandom_range(0, 3) != 0);
      else         rdy_b = ($urandom_range(0, 3) != 0);
      send_frame(id, d, p, s1, s2, -1, 1);
      idle(200 + $urandom_range(0, 150));
    end

    rdy_a = 1'b1;
    rdy_b = 1'b1;
    idle(20);
    check("end_q_a", exp_q_a.size(), 0);
    check("end_q_b", exp_q_b.size(), 0);
    check("end_ovr_a", ovr_cnt[0], exp_ovr[0]);
    check("end_ovr_b", ovr_cnt[1], exp_ovr[1]);
    check("end_brk_a", brk_cnt[0], exp_brk[0]);
    check("end_brk_b", brk_cnt[1], exp_brk[1]);
    check("end_valid_a", v_a, 0);
    check("end_valid_b", v_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised successor to the basic UART receiver. It uses 16x oversampling with a 3-sample majority vote, configurable data bits, parity and stop bits, and per-frame parity/framing error flags. It also provides break detection, overrun reporting and a valid/ready output handshake backed by a one-entry holding register. It sits between the board RX pin and the byte-consuming logic (command parser or RX FIFO).

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; 1 or 2
OVERSAMPLE, 16, ticks per bit; even, >= 8

Ports:
clock  input  1  system clock; all logic on its rising edge
reset_n  input  1  asynchronous, active-low reset
rx  input  1  asynchronous serial line; idles high
rx_data  output  DATA_BITS  received word, LSB = first bit on the line
rx_parity_err  output  1  parity error flag for the word in rx_data
rx_frame_err  output  1  framing error flag for the word in rx_data
rx_valid  output  1  rx_data and its flags are valid
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready
overrun  output  1  one-cycle pulse: a completed frame was dropped
break_det  output  1  one-cycle pulse: break condition detected

Behaviour:
- Reset (asserting reset_n low, at any time, including mid-frame):
  - state = IDLE; all counters cleared.
  - rx_data = 0; rx_parity_err, rx_frame_err, rx_valid, overrun and break_det all = 0.
  - Synchronizer flops are set to 1.
- rx passes through a 2-flop synchronizer. All references to "rx" below mean the synchronized value (2 cycles of latency).
- Tick generator:
  - TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE), integer division.
  - A free-running counter emits a one-cycle tick every TICK_DIV clocks.
  - The counter restarts on entry to START, so ticks are phase-aligned to the start edge.
- Bit timing:
  - tick_cnt counts 0..OVERSAMPLE-1 within each bit. Let M = OVERSAMPLE/2.
  - rx is sampled on ticks M-1, M and M+1. The bit value is the 2-of-3 majority, decided on tick M+1.
  - A bit ends on tick OVERSAMPLE-1, except where noted below.
- State machine:
  - IDLE: on rx == 0 go to START and clear tick_cnt and bit_cnt.
  - START: at the decision tick, majority 1 means a false start; return to IDLE with no outputs. Majority 0 means continue; at the end of the bit go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit go to PARITY if PARITY != 0, otherwise go to STOP.
  - PARITY: the sampled bit is checked against the data. For even parity (PARITY = 1), the XOR of data bits and parity bit must be 0. For odd parity (PARITY = 2), it must be 1. A mismatch sets the parity error.
  - STOP: each of the STOP_BITS stop bits must be majority 1, otherwise a framing error is recorded. On the decision tick of the last stop bit, complete the frame and go directly to IDLE. The receiver does not wait for the end of the bit, which gives resync margin.
- Break:
  - Condition: at frame completion, all data bits = 0, the parity bit (if present) = 0 and the first stop bit = 0.
  - Response: pulse break_det for one cycle, deliver no data, and go to BREAK.
  - BREAK: wait for rx == 1, then go to IDLE.
- Output handshake:
  - Frame completion: if the holding register is free, or is being consumed this cycle (rx_valid && rx_ready), then on the next clock edge rx_data and both error flags load and rx_valid = 1.
  - rx_valid, rx_data and the flags hold stable until accepted. rx_valid clears on the edge where rx_valid && rx_ready, unless a new frame loads in the same cycle.
  - Completion while rx_valid && !rx_ready: the new frame is discarded, overrun pulses for one cycle, and the held word is untouched.
- Frames with parity or framing errors are still delivered, with their flags set.
- Latency: rx_valid rises 1 clock after the last stop-bit decision tick, i.e. about 3 clocks plus the sampling delay after the line edge.

Test Plan:
All scenarios use CLOCK_FREQ = 1536000, BAUD_RATE = 9600, OVERSAMPLE = 16, so TICK_DIV = 10 and one bit = 160 clocks.
1. 8N1, rx_ready tied high, send 0xA5 -> rx_valid high for exactly 1 cycle, rx_data = 0xA5, both error flags 0. Reassert reset_n low mid-frame on a second 0xA5 -> no rx_valid; the next frame 0x5A is received correctly.
2. PARITY = 1, send 0x3C with parity bit 1 (correct is 0) -> rx_data = 0x3C, rx_parity_err = 1. Resend with parity 0 -> rx_parity_err = 0.
3. 8N1, send 0x55 with stop bit 0 -> rx_data = 0x55, rx_frame_err = 1. STOP_BITS = 2 with second stop bit 0 -> rx_frame_err = 1.
4. Low glitch of 40 clocks on an idle line -> no rx_valid, FSM back in IDLE. Send 0x81 with a 10-clock inverted spike at the centre of bit 3 -> rx_data = 0x81 (majority rejects the spike).
5. rx_ready low, send 0x11 then 0x22 -> rx_valid holds 0x11, overrun pulses once when 0x22 completes. Raise rx_ready -> 0x11 accepted, rx_valid drops, 0x22 is never presented.
6. Hold rx low for 3200 clocks -> exactly one break_det pulse, no rx_valid. Release rx high, send 0x7E -> rx_data = 0x7E with no error flags.
